// File: rtl/lcd16x2_nibble_writer.sv
// HD44780 4-bit write engine: power-up init (0x3,0x3,0x3,0x2) followed by
// byte writes split into high/low nibbles with timed E pulses and post-command waits.
module lcd16x2_nibble_writer #(
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned E_HIGH_CYC    = 4,
  parameter int unsigned CMD_WAIT_CYC  = 320,
  parameter int unsigned LONG_WAIT_CYC = 13120,
  parameter int unsigned POWERUP_CYC   = 320000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       rs_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       init_done_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [3:0] lcd_d_o
);

  localparam int unsigned SetupC   = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
  localparam int unsigned EHighC   = (E_HIGH_CYC == 0) ? 1 : E_HIGH_CYC;
  localparam int unsigned CmdC     = (CMD_WAIT_CYC == 0) ? 1 : CMD_WAIT_CYC;
  localparam int unsigned LongC    = (LONG_WAIT_CYC == 0) ? 1 : LONG_WAIT_CYC;
  localparam int unsigned PowerupC = (POWERUP_CYC == 0) ? 1 : POWERUP_CYC;
  localparam int unsigned NibC     = SetupC + EHighC;

  localparam int unsigned MaxA = (PowerupC > LongC) ? PowerupC : LongC;
  localparam int unsigned MaxB = (CmdC > NibC) ? CmdC : NibC;
  localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned ReqW = $clog2(MaxC + 1);
  localparam int unsigned CntW = (ReqW > 19) ? ReqW : 19;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntSetup   = cnt_t'(SetupC);
  localparam cnt_t CntEHigh   = cnt_t'(EHighC);
  localparam cnt_t CntCmd     = cnt_t'(CmdC);
  localparam cnt_t CntLong    = cnt_t'(LongC);
  localparam cnt_t CntPowerup = cnt_t'(PowerupC);
  localparam cnt_t CntNib     = cnt_t'(NibC);

  typedef enum logic [3:0] {
    StPwrWait, StInitNib, StInitWait, StIdle, StSetupHi,
    StEHi, StGap, StSetupLo, StELo, StPostWait
  } state_e;

  state_e     state_q;
  cnt_t       cnt_q;
  logic [1:0] step_q;
  logic [7:0] data_q;
  logic       rs_q;
  logic       ready_q;
  logic       init_done_q;
  logic       lcd_rs_q;
  logic       lcd_e_q;
  logic [3:0] lcd_d_q;

  cnt_t       cnt_dec;
  logic       cnt_last;
  logic [1:0] step_nxt;
  logic [3:0] nib_nxt;
  cnt_t       init_wait;
  logic       long_cmd;

  assign cnt_dec   = cnt_q - cnt_t'(1);
  assign cnt_last  = (cnt_q == cnt_t'(1));
  assign step_nxt  = step_q + 2'd1;
  assign nib_nxt   = (step_nxt == 2'd3) ? 4'h2 : 4'h3;
  assign init_wait = (step_q == 2'd0) ? CntLong : CntCmd;
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign long_cmd  = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StPwrWait;
      cnt_q       <= CntPowerup;
      step_q      <= 2'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_d_q     <= 4'h0;
    end else begin
      unique case (state_q)
        StPwrWait: begin
          if (cnt_last) begin
            state_q  <= StInitNib;
            cnt_q    <= CntNib;
            step_q   <= 2'd0;
            lcd_d_q  <= 4'h3;
            lcd_rs_q <= 1'b0;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        // Counter runs NibC..1; E is high for the last EHighC counts.
        StInitNib: begin
          if (cnt_last) begin
            state_q <= StInitWait;
            cnt_q   <= init_wait;
            lcd_e_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_dec;
            lcd_e_q <= (cnt_dec <= CntEHigh);
          end
        end
        StInitWait: begin
          if (cnt_last) begin
            if (step_q == 2'd3) begin
              state_q     <= StIdle;
              init_done_q <= 1'b1;
            end else begin
              state_q <= StInitNib;
              cnt_q   <= CntNib;
              step_q  <= step_nxt;
              lcd_d_q <= nib_nxt;
            end
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        // ready is registered from IDLE, so it asserts one clock after entry.
        StIdle: begin
          if (ready_q && valid_i) begin
            state_q  <= StSetupHi;
            cnt_q    <= CntSetup;
            ready_q  <= 1'b0;
            data_q   <= data_i;
            rs_q     <= rs_i;
            lcd_rs_q <= rs_i;
            lcd_d_q  <= data_i[7:4];
          end else begin
            ready_q <= 1'b1;
          end
        end
        StSetupHi: begin
          if (cnt_last) begin
            state_q <= StEHi;
            cnt_q   <= CntEHigh;
            lcd_e_q <= 1'b1;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        StEHi: begin
          if (cnt_last) begin
            state_q <= StGap;
            cnt_q   <= CntEHigh;
            lcd_e_q <= 1'b0;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        StGap: begin
          if (cnt_last) begin
            state_q <= StSetupLo;
            cnt_q   <= CntSetup;
            lcd_d_q <= data_q[3:0];
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        StSetupLo: begin
          if (cnt_last) begin
            state_q <= StELo;
            cnt_q   <= CntEHigh;
            lcd_e_q <= 1'b1;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        StELo: begin
          if (cnt_last) begin
            state_q <= StPostWait;
            cnt_q   <= long_cmd ? CntLong : CntCmd;
            lcd_e_q <= 1'b0;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        StPostWait: begin
          if (cnt_last) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_dec;
          end
        end
        default: begin
          state_q <= StPwrWait;
          cnt_q   <= CntPowerup;
          lcd_e_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign init_done_o = init_done_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_e_o     = lcd_e_q;
  assign lcd_d_o     = lcd_d_q;

endmodule

// File: tb/tb_lcd16x2_nibble_writer.sv
// Directed bench for lcd16x2_nibble_writer with small timing parameters
// (SETUP=1, E_HIGH=2, CMD=5, LONG=10, POWERUP=20).
module tb_lcd16x2_nibble_writer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       rs_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       init_done_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_e_o;
  logic [3:0] lcd_d_o;

  int vectors = 0;
  int errors  = 0;

  lcd16x2_nibble_writer #(
    .SETUP_CYC    (1),
    .E_HIGH_CYC   (2),
    .CMD_WAIT_CYC (5),
    .LONG_WAIT_CYC(10),
    .POWERUP_CYC  (20)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .rs_i       (rs_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .init_done_o(init_done_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_e_o    (lcd_e_o),
    .lcd_d_o    (lcd_d_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle on the falling edge for sampling/driving.
  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    valid_i = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ready_o, init_done_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_d_o} !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {ready_o, init_done_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_d_o}, 9'h000);
    end
  endtask

  // Assumes the previous edge sampled rst_i high; n counts edges after release.
  task automatic test_init;
    int rise_at[4];
    logic [3:0] nib[4];
    int rises;
    logic prev_e;
    logic e_exp;
    rise_at = '{21, 34, 42, 50};
    nib = '{4'h3, 4'h3, 4'h3, 4'h2};
    rises = 0;
    prev_e = 1'b0;
    rst_i = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      e_exp = (n == 21 || n == 22 || n == 34 || n == 35 ||
               n == 42 || n == 43 || n == 50 || n == 51);
      vectors++;
      if (lcd_e_o !== e_exp) begin
        errors++;
        $display("FAIL init_e cycle %0d: got %b want %b", n, lcd_e_o, e_exp);
      end
      vectors++;
      if ({lcd_rs_o, lcd_rw_o} !== 2'b00) begin
        errors++;
        $display("FAIL init_rs_rw cycle %0d: got %b want 00", n, {lcd_rs_o, lcd_rw_o});
      end
      vectors++;
      if (init_done_o !== (n >= 57)) begin
        errors++;
        $display("FAIL init_done cycle %0d: got %b want %b", n, init_done_o, n >= 57);
      end
      vectors++;
      if (ready_o !== (n >= 58)) begin
        errors++;
        $display("FAIL init_ready cycle %0d: got %b want %b", n, ready_o, n >= 58);
      end
      if (lcd_e_o === 1'b1 && prev_e === 1'b0) begin
        if (rises < 4) begin
          vectors++;
          if (n !== rise_at[rises] || lcd_d_o !== nib[rises]) begin
            errors++;
            $display("FAIL init_nibble %0d: got cycle %0d d=%h want cycle %0d d=%h",
                     rises, n, lcd_d_o, rise_at[rises], nib[rises]);
          end
        end
        rises++;
      end
      prev_e = lcd_e_o;
    end
    vectors++;
    if (rises !== 4) begin
      errors++;
      $display("FAIL init_rise_count: got %0d want 4", rises);
    end
  endtask

  task automatic test_data_byte;
    logic e_exp;
    logic [3:0] d_exp;
    data_i = 8'h48;
    rs_i = 1'b1;
    valid_i = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      valid_i = 1'b0;
      e_exp = (k == 1 || k == 2 || k == 6 || k == 7);
      d_exp = (k < 5) ? 4'h4 : 4'h8;
      vectors++;
      if ({lcd_e_o, lcd_d_o, lcd_rs_o} !== {e_exp, d_exp, 1'b1}) begin
        errors++;
        $display("FAIL data_byte_bus k=%0d: got e=%b d=%h rs=%b want e=%b d=%h rs=1",
                 k, lcd_e_o, lcd_d_o, lcd_rs_o, e_exp, d_exp);
      end
      vectors++;
      if (ready_o !== (k == 14)) begin
        errors++;
        $display("FAIL data_byte_ready k=%0d: got %b want %b", k, ready_o, k == 14);
      end
    end
  endtask

  task automatic test_clear;
    logic e_exp;
    logic [3:0] d_exp;
    data_i = 8'h01;
    rs_i = 1'b0;
    valid_i = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      tick();
      valid_i = 1'b0;
      e_exp = (k == 1 || k == 2 || k == 6 || k == 7);
      d_exp = (k < 5) ? 4'h0 : 4'h1;
      vectors++;
      if ({lcd_e_o, lcd_d_o, lcd_rs_o} !== {e_exp, d_exp, 1'b0}) begin
        errors++;
        $display("FAIL clear_bus k=%0d: got e=%b d=%h rs=%b want e=%b d=%h rs=0",
                 k, lcd_e_o, lcd_d_o, lcd_rs_o, e_exp, d_exp);
      end
      vectors++;
      if (ready_o !== (k == 19)) begin
        errors++;
        $display("FAIL clear_ready k=%0d: got %b want %b", k, ready_o, k == 19);
      end
    end
  endtask

  task automatic test_valid_busy;
    logic e_exp;
    logic [3:0] d_exp;
    data_i = 8'h5A;
    rs_i = 1'b1;
    valid_i = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      tick();
      e_exp = (k == 1 || k == 2 || k == 6 || k == 7);
      d_exp = (k < 5) ? 4'h5 : 4'hA;
      vectors++;
      if ({lcd_e_o, lcd_d_o, lcd_rs_o} !== {e_exp, d_exp, 1'b1}) begin
        errors++;
        $display("FAIL busy_bus k=%0d: got e=%b d=%h rs=%b want e=%b d=%h rs=1",
                 k, lcd_e_o, lcd_d_o, lcd_rs_o, e_exp, d_exp);
      end
      vectors++;
      if (ready_o !== (k == 14)) begin
        errors++;
        $display("FAIL busy_ready k=%0d: got %b want %b", k, ready_o, k == 14);
      end
      if (k < 14) begin
        data_i = 8'h81 + 8'(k * 7);
        rs_i = k[0];
      end else begin
        data_i = 8'h3C;
        rs_i = 1'b0;
      end
    end
    tick();
    vectors++;
    if ({ready_o, lcd_e_o, lcd_d_o, lcd_rs_o} !== {1'b0, 1'b0, 4'h3, 1'b0}) begin
      errors++;
      $display("FAIL busy_next_accept: got ready=%b e=%b d=%h rs=%b want ready=0 e=0 d=3 rs=0",
               ready_o, lcd_e_o, lcd_d_o, lcd_rs_o);
    end
    valid_i = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == 5) begin
        vectors++;
        if (lcd_d_o !== 4'hC) begin
          errors++;
          $display("FAIL busy_second_low_nibble: got %h want c", lcd_d_o);
        end
      end
      if (j == 14) begin
        vectors++;
        if (ready_o !== 1'b1) begin
          errors++;
          $display("FAIL busy_second_ready: got %b want 1", ready_o);
        end
      end
    end
  endtask

  task automatic test_midbyte_reset;
    data_i = 8'h48;
    rs_i = 1'b1;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    vectors++;
    if (lcd_e_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_e_high: got %b want 1", lcd_e_o);
    end
    rst_i = 1'b1;
    tick();
    vectors++;
    if ({ready_o, init_done_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_d_o} !== 9'h000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b want %b",
               {ready_o, init_done_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_d_o}, 9'h000);
    end
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_byte();
    test_clear();
    test_valid_busy();
    test_midbyte_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
